equal_gate_ctrl: RTL and testbench
==================================

// Module: equal_gate_ctrl
// PURPOSE
//  Gate-control front end of the equal-precision frequency meter; sits directly upstream of the 6-digit BCD counter.
//  Generates a preset gate resynchronised to rising edges of the measured signal F_IN, so the gate always spans an
//  integer number of F_IN periods. Drives the counter's EN/CLR and latches a strobe.
//  Counts reference clocks (REF_CNT) and signal edges (SIG_CNT) over the same gate; downstream f = SIG/REF*f_CLK.
// PARAMETERS
//  GATE_CYCLES    50_000_000   preset gate length in CLK cycles (1 s at 50 MHz), >=2
//  CLR_CYCLES     4            CLK cycles CLR is held high before arming, >=1
//  CNT_W          32           width of REF_CNT / SIG_CNT
//  TIMEOUT_CYCLES 100_000_000  max CLK cycles waiting for an F_IN edge (macro build only)
// PORTS
//  CLK      in   1      reference clock; all logic on posedge
//  RST_N    in   1      asynchronous active-low reset
//  F_IN     in   1      measured signal, asynchronous to CLK
//  START    in   1      one-cycle request to begin a measurement; ignored while BUSY=1
//  EN       out  1      gate to BCD counter; high exactly while gate open
//  CLR      out  1      clear to BCD counter; high in CLEAR state
//  LATCH    out  1      one-cycle pulse after gate closes; counter/REF/SIG values valid
//  BUSY     out  1      high in every state except IDLE
//  DONE     out  1      set with LATCH, held until next accepted START or reset
//  REF_CNT  out  CNT_W  CLK cycles with EN=1 in last measurement; held after DONE
//  SIG_CNT  out  CNT_W  F_IN rising edges closing periods in last gate; held after DONE
//  ERR      out  1      only when GATE_TIMEOUT_EN defined; see CONFIGURATION
// BEHAVIOUR
//  Reset: async on RST_N=0; state=IDLE, EN=CLR=LATCH=BUSY=DONE=0, REF_CNT=SIG_CNT=0, sync FFs=0, ERR=0.
//  Sync: F_IN -> 3 FFs (s1,s2,s3); RISE = s2 & ~s3; RISE is 3 CLK after the F_IN edge (fixed, cancels at both ends).
//  FSM (all outputs registered):
//   IDLE : START=1 -> CLEAR; DONE<=0, REF_CNT<=0, SIG_CNT<=0, BUSY<=1.
//   CLEAR: CLR=1 for CLR_CYCLES cycles -> ARM.
//   ARM  : wait RISE; on RISE -> GATE, EN<=1, gate timer<=0. Opening edge not counted.
//   GATE : EN=1; REF_CNT+1 every cycle EN=1; timer+1 per cycle; TDONE flag set when timer=GATE_CYCLES-1.
//          RISE with TDONE=0 -> SIG_CNT+1, stay. RISE with TDONE=1 (flag already registered) -> SIG_CNT+1,
//          EN<=0 -> LATCH. RISE in the same cycle TDONE sets does not close.
//   LATCH: LATCH=1 one cycle, DONE<=1 -> IDLE (BUSY<=0 on exit).
//  Gate length = SIG_CNT * F_IN period exactly; REF_CNT = cycles EN high.
//  REF_CNT / SIG_CNT saturate at all-ones (no wrap); measurement still completes.
//  START while BUSY=1: ignored, no restart. START in the LATCH-exit cycle: ignored; accepted from IDLE only.
//  F_IN stuck (no RISE): base build waits in ARM/GATE indefinitely; new START has no effect until reset.
//  RST_N low mid-measurement: immediate return to reset values; partial counts discarded, EN drops async.
// CONFIGURATION
//  GATE_TIMEOUT_EN defined: watchdog counts cycles since last RISE (or entry) in ARM and GATE; at TIMEOUT_CYCLES
//   -> EN<=0, ERR<=1, DONE<=1, no LATCH pulse, counts held, -> IDLE. ERR cleared on next accepted START.
//  Not defined: no watchdog, no ERR port, behaviour as above.
// TESTING (GATE_CYCLES=95, CLR_CYCLES=4, CNT_W=16 unless stated)
//  1 Reset: RST_N=0 with F_IN toggling -> all outputs 0; release -> IDLE, BUSY=0.
//  2 F_IN period 10 CLK, START -> CLR high 4 cycles; EN high 100 cycles; SIG_CNT=10, REF_CNT=100, LATCH 1 pulse, DONE=1.
//  3 F_IN period 7 CLK -> gate closes on first edge after 95 -> REF_CNT=98, SIG_CNT=14.
//  4 START pulsed mid-GATE and in LATCH cycle -> ignored, results as scenario 2.
//  5 RST_N low 50 cycles into GATE -> EN=0 at once, counts 0; new START gives scenario 2 result.
//  6 GATE_TIMEOUT_EN, TIMEOUT_CYCLES=200, F_IN held 0 -> after 200 cycles in ARM ERR=1, DONE=1, LATCH never pulses.

Source files
------------

// File: rtl/equal_gate_ctrl_if.sv
// Interface bundle for the equal-precision gate controller.
// Carries the measured signal, the start request, the BCD counter controls and the results.
// Optional build macro: GATE_TIMEOUT_EN adds the err signal used by the F_IN watchdog.
interface equal_gate_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             f_in;
    logic             start;
    logic             en;
    logic             clr;
    logic             latch;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] ref_cnt;
    logic [CNT_W-1:0] sig_cnt;
`ifdef GATE_TIMEOUT_EN
    logic             err;

    modport master (
        output f_in, start,
        input  en, clr, latch, busy, done, ref_cnt, sig_cnt, err
    );

    modport slave (
        input  f_in, start,
        output en, clr, latch, busy, done, ref_cnt, sig_cnt, err
    );
`else
    modport master (
        output f_in, start,
        input  en, clr, latch, busy, done, ref_cnt, sig_cnt
    );

    modport slave (
        input  f_in, start,
        output en, clr, latch, busy, done, ref_cnt, sig_cnt
    );
`endif
endinterface

// File: rtl/equal_gate_ctrl.sv
// Gate-control front end of the equal-precision frequency meter.
// Opens and closes the counting gate on synchronised rising edges of f_in so the gate spans
// an integer number of f_in periods; counts reference cycles and signal edges over that gate.
// Optional build macro: GATE_TIMEOUT_EN adds a watchdog on missing f_in edges and the err output.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; results and done held
// S_CLEAR | clr high to the BCD counter for CLR_CYCLES cycles
// S_ARM   | waiting for the opening f_in edge
// S_GATE  | en high; counting; closes on first edge after preset time
// S_LATCH | one-cycle latch pulse, results valid
module equal_gate_ctrl #(
    parameter int GATE_CYCLES    = 50_000_000,
    parameter int CLR_CYCLES     = 4,
    parameter int CNT_W          = 32
`ifdef GATE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 100_000_000
`endif
) (
    input logic              clk_i,
    input logic              rst_n_i,
    equal_gate_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ARM,
        S_GATE,
        S_LATCH
    } state_t;

    // One shared down-counter serves both the clear hold and the preset gate time.
    localparam int TMAX = (GATE_CYCLES > CLR_CYCLES) ? GATE_CYCLES : CLR_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    state_t           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             tdone_q, tdone_d;
    logic [CNT_W-1:0] ref_q, ref_d;
    logic [CNT_W-1:0] sig_q, sig_d;
    logic             en_q, en_d;
    logic             clr_q, clr_d;
    logic             latch_q, latch_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             s1_q, s2_q, s3_q;
    logic             rise;

`ifdef GATE_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0]    wd_q, wd_d;
    logic             err_q, err_d;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign rise = s2_q & ~s3_q;

    // Three-stage synchroniser for the asynchronous measured signal; edge detect on the last two.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus.f_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Next-state, timer and counter logic; outputs are derived from the next state so they register with it.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        tdone_d = tdone_q;
        ref_d   = ref_q;
        sig_d   = sig_q;
        done_d  = done_q;
`ifdef GATE_TIMEOUT_EN
        wd_d    = WW'(TIMEOUT_CYCLES - 1);
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CLEAR;
                    tmr_d   = TW'(CLR_CYCLES - 1);
                    done_d  = 1'b0;
                    ref_d   = '0;
                    sig_d   = '0;
`ifdef GATE_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_CLEAR: begin
                if (tmr_q == '0) begin
                    state_d = S_ARM;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_ARM: begin
                // The opening edge starts the gate but is not itself a counted period.
                if (rise) begin
                    state_d = S_GATE;
                    tmr_d   = TW'(GATE_CYCLES - 1);
                    tdone_d = 1'b0;
                end
            end
            S_GATE: begin
                ref_d = sat_inc(ref_q);
                if (tmr_q == '0) begin
                    tdone_d = 1'b1;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
                // Only an already-registered tdone closes, so an edge coinciding with expiry keeps the gate open.
                if (rise) begin
                    sig_d = sat_inc(sig_q);
                    if (tdone_q) begin
                        state_d = S_LATCH;
                        done_d  = 1'b1;
                    end
                end
            end
            S_LATCH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef GATE_TIMEOUT_EN
        // Watchdog restarts on every edge; abandons the measurement without a latch pulse.
        if ((state_q == S_ARM) || (state_q == S_GATE)) begin
            if (rise) begin
                wd_d = WW'(TIMEOUT_CYCLES - 1);
            end else if (wd_q == '0) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                err_d   = 1'b1;
            end else begin
                wd_d = wd_q - WW'(1);
            end
        end
`endif
        en_d    = (state_d == S_GATE);
        clr_d   = (state_d == S_CLEAR);
        latch_d = (state_d == S_LATCH);
        busy_d  = (state_d != S_IDLE);
    end

    // State, timer, counter and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            tdone_q <= 1'b0;
            ref_q   <= '0;
            sig_q   <= '0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef GATE_TIMEOUT_EN
            wd_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            tdone_q <= tdone_d;
            ref_q   <= ref_d;
            sig_q   <= sig_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
            latch_q <= latch_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef GATE_TIMEOUT_EN
            wd_q    <= wd_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.en      = en_q;
    assign bus.clr     = clr_q;
    assign bus.latch   = latch_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ref_cnt = ref_q;
    assign bus.sig_cnt = sig_q;
`ifdef GATE_TIMEOUT_EN
    assign bus.err     = err_q;
`endif

endmodule

// File: tb/tb_equal_gate_ctrl.sv
// Self-checking bench for equal_gate_ctrl: table of fixed F_IN periods, hand-written corner
// sequences, and random F_IN waveforms checked against an edge-timestamp reference model.
module tb_equal_gate_ctrl;
    localparam int GATE   = 95;
    localparam int CLRC   = 4;
    localparam int SAT_MX = 31;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic f_in  = 1'b0;
    logic start = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rises[$];

    bit fin_run  = 1'b0;
    bit fin_rand = 1'b0;
    bit fin_lvl  = 1'b0;
    int hi_len   = 5;
    int lo_len   = 5;
    int ph_cnt   = 0;

    typedef struct {
        int per;
        int ref_e;
        int sig_e;
    } vec_t;
    vec_t tbl[8];

    equal_gate_ctrl_if #(.CNT_W(16)) if_a ();
    equal_gate_ctrl_if #(.CNT_W(5))  if_b ();

    assign if_a.f_in  = f_in;
    assign if_a.start = start;
    assign if_b.f_in  = f_in;
    assign if_b.start = start;

`ifdef GATE_TIMEOUT_EN
    equal_gate_ctrl #(.GATE_CYCLES(GATE), .CLR_CYCLES(CLRC), .CNT_W(16), .TIMEOUT_CYCLES(200)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .bus(if_a));
    equal_gate_ctrl #(.GATE_CYCLES(GATE), .CLR_CYCLES(CLRC), .CNT_W(5), .TIMEOUT_CYCLES(200)) u_sat (
        .clk_i(clk), .rst_n_i(rst_n), .bus(if_b));
`else
    equal_gate_ctrl #(.GATE_CYCLES(GATE), .CLR_CYCLES(CLRC), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .bus(if_a));
    equal_gate_ctrl #(.GATE_CYCLES(GATE), .CLR_CYCLES(CLRC), .CNT_W(5)) u_sat (
        .clk_i(clk), .rst_n_i(rst_n), .bus(if_b));
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // F_IN generator: changes only at negedges; records the posedge index at which each rise is first sampled.
    always @(negedge clk) begin
        if (fin_run) begin
            if (ph_cnt == 0) begin
                fin_lvl = ~fin_lvl;
                if (fin_lvl) rises.push_back(cyc + 1);
                if (fin_rand) ph_cnt = $urandom_range(6, 1) - 1;
                else          ph_cnt = (fin_lvl ? hi_len : lo_len) - 1;
            end else begin
                ph_cnt--;
            end
        end
        f_in = fin_lvl;
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    task automatic set_period(input int p);
        hi_len   = p / 2;
        lo_len   = p - p / 2;
        fin_rand = 1'b0;
        fin_run  = 1'b1;
    endtask

    // Reference: the gate opens on the first edge seen after the clear phase, spans whole periods,
    // and closes on the first edge at least GATE+1 cycles after opening; REF = span, SIG = closed periods.
    function automatic void model(input int m, output int r, output int s);
        int open;
        open = -1;
        r    = -1;
        s    = 0;
        foreach (rises[i]) begin
            if (open < 0) begin
                if (rises[i] >= m + 3) open = rises[i];
            end else if (r < 0) begin
                s++;
                if (rises[i] - open >= GATE + 1) r = rises[i] - open;
            end
        end
    endfunction

    task automatic measure(input string tag, input bit use_model, input int exp_ref,
                           input int exp_sig, input bit inject);
        int m, en_c, clr_c, lat_c, er, es;
        bit seen;
        @(negedge clk);
        rises.delete();
        start = 1'b1;
        m     = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done_cleared"}, int'(if_a.done), 0);
        chk({tag, "_busy_set"}, int'(if_a.busy), 1);
        en_c  = 0;
        clr_c = 0;
        lat_c = 0;
        seen  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (if_a.en)    en_c++;
            if (if_a.clr)   clr_c++;
            if (if_a.latch) begin
                lat_c++;
                seen = 1'b1;
            end
            if (seen && !if_a.latch) break;
            start = inject && ((en_c == 30) || if_a.latch);
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_finished"}, int'(seen), 1);
        if (use_model) model(m, er, es);
        else begin
            er = exp_ref;
            es = exp_sig;
        end
        chk({tag, "_ref_cnt"}, int'(if_a.ref_cnt), er);
        chk({tag, "_sig_cnt"}, int'(if_a.sig_cnt), es);
        chk({tag, "_en_cycles"}, en_c, er);
        chk({tag, "_clr_cycles"}, clr_c, CLRC);
        chk({tag, "_latch_pulses"}, lat_c, 1);
        chk({tag, "_sat_ref"}, int'(if_b.ref_cnt), (er > SAT_MX) ? SAT_MX : er);
        chk({tag, "_sat_sig"}, int'(if_b.sig_cnt), (es > SAT_MX) ? SAT_MX : es);
        repeat (3) @(negedge clk);
        chk({tag, "_done_held"}, int'(if_a.done), 1);
        chk({tag, "_busy_idle"}, int'(if_a.busy), 0);
    endtask

    initial begin
        int n;
        int lat_c;
        tbl[0] = '{per: 10, ref_e: 100, sig_e: 10};
        tbl[1] = '{per: 7,  ref_e: 98,  sig_e: 14};
        tbl[2] = '{per: 5,  ref_e: 100, sig_e: 20};
        tbl[3] = '{per: 2,  ref_e: 96,  sig_e: 48};
        tbl[4] = '{per: 95, ref_e: 190, sig_e: 2};
        tbl[5] = '{per: 96, ref_e: 96,  sig_e: 1};
        tbl[6] = '{per: 48, ref_e: 96,  sig_e: 2};
        tbl[7] = '{per: 19, ref_e: 114, sig_e: 6};

        // Reset held with F_IN toggling.
        set_period(3);
        repeat (10) @(negedge clk);
        chk("rst_en", int'(if_a.en), 0);
        chk("rst_clr", int'(if_a.clr), 0);
        chk("rst_latch", int'(if_a.latch), 0);
        chk("rst_busy", int'(if_a.busy), 0);
        chk("rst_done", int'(if_a.done), 0);
        chk("rst_ref", int'(if_a.ref_cnt), 0);
        chk("rst_sig", int'(if_a.sig_cnt), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", int'(if_a.busy), 0);
        chk("post_rst_en", int'(if_a.en), 0);

        // Fixed-period table.
        for (int i = 0; i < 8; i++) begin
            set_period(tbl[i].per);
            measure($sformatf("per%0d", tbl[i].per), 1'b0, tbl[i].ref_e, tbl[i].sig_e, 1'b0);
        end

        // START mid-gate and in the latch cycle must be ignored.
        set_period(10);
        measure("inject", 1'b0, 100, 10, 1'b1);

        // Reset 50 cycles into the gate, then a clean rerun.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 2000 && n < 50; i++) begin
            @(negedge clk);
            if (if_a.en) n++;
        end
        chk("midgate_reached", n, 50);
        chk("midgate_ref_nonzero", int'(if_a.ref_cnt != 0), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_en", int'(if_a.en), 0);
        chk("midrst_ref", int'(if_a.ref_cnt), 0);
        chk("midrst_sig", int'(if_a.sig_cnt), 0);
        chk("midrst_busy", int'(if_a.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        measure("after_rst", 1'b0, 100, 10, 1'b0);

        // Random F_IN waveforms against the reference model.
        fin_rand = 1'b1;
        for (int i = 0; i < 8; i++) measure($sformatf("rnd%0d", i), 1'b1, 0, 0, 1'b0);

        // F_IN stuck low.
        fin_run = 1'b0;
        fin_lvl = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat_c = 0;
        repeat (250) begin
            @(negedge clk);
            if (if_a.latch) lat_c++;
        end
        chk("stuck_en", int'(if_a.en), 0);
        chk("stuck_latch", lat_c, 0);
`ifdef GATE_TIMEOUT_EN
        chk("stuck_err", int'(if_a.err), 1);
        chk("stuck_done", int'(if_a.done), 1);
        chk("stuck_busy", int'(if_a.busy), 0);
        set_period(10);
        measure("after_timeout", 1'b0, 100, 10, 1'b0);
        chk("err_cleared", int'(if_a.err), 0);
`else
        chk("stuck_busy", int'(if_a.busy), 1);
        chk("stuck_done", int'(if_a.done), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("stuck_no_restart_clr", int'(if_a.clr), 0);
        chk("stuck_still_busy", int'(if_a.busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_period(10);
        measure("after_stuck", 1'b0, 100, 10, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
